// File: rtl/mem_bus_responder_if.sv
// Request/response bus between the datapath memory port
// and the memory responder.
interface mem_bus_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [63:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr,
    output req_size, req_unsigned, req_wdata,
    output rsp_ready,
    input  req_ready, rsp_valid,
    input  rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr,
    input  req_size, req_unsigned, req_wdata,
    input  rsp_ready,
    output req_ready, rsp_valid,
    output rsp_rdata, rsp_err
  );
endinterface

// File: rtl/mem_bus_responder.sv
// Memory bus responder: instruction/data decode, 64-bit data array.
// Optional access wait states via MEM_WAIT_STATES_EN.
module mem_bus_responder #(
  parameter logic [63:0] DATA_BASE   = 64'h2000,
  parameter int          DATA_WORDS  = 512,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  mem_bus_responder_if.slave bus,
  output logic [63:0] im_addr,
  input  logic [31:0] im_data
);

  localparam int IW = $clog2(DATA_WORDS);
  localparam logic [63:0] SPAN = 64'(DATA_WORDS) << 3;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state, state_nx;

  logic        we_q;
  logic [63:0] addr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [63:0] wdata_q;
  logic [63:0] rdata_q;
  logic        err_q;

  logic accept;
  logic fire;
  logic done;
  logic ready;

  logic [63:0] mem [DATA_WORDS];

  logic [63:0]   off;
  logic          in_instr;
  logic          in_data;
  logic          misalign;
  logic          err_nx;
  logic [IW-1:0] idx;
  logic [2:0]    lane;
  logic [63:0]   word;
  logic [63:0]   shifted;
  logic [63:0]   ext;
  logic [63:0]   rdata_nx;
  logic [7:0]    be_base;
  logic [7:0]    be;
  logic [63:0]   wshift;
  logic [63:0]   merged;

`ifdef MEM_WAIT_STATES_EN
  localparam int CW =
    (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
  logic [CW-1:0] cnt_q;
  assign done = (cnt_q == '0);
`else
  assign done = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    ready    = 1'b0;
    accept   = 1'b0;
    fire     = 1'b0;
    bus.rsp_valid = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.req_valid) begin
          accept   = 1'b1;
          state_nx = ACCESS;
        end
      end
      ACCESS: begin
        if (done) begin
          fire     = 1'b1;
          state_nx = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign bus.req_ready = ready & reset;
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;
  assign im_addr       = {2'b00, addr_q[63:2]};

  always_comb begin
    off      = addr_q - DATA_BASE;
    in_instr = (addr_q < DATA_BASE);
    in_data  = !in_instr && (off < SPAN);
    idx      = off[IW+2:3];
    lane     = addr_q[2:0];
    word     = mem[idx];
    shifted  = word >> {lane, 3'b000};
    misalign = 1'b0;
    ext      = shifted;
    be_base  = 8'hFF;
    unique case (size_q)
      2'd0: begin
        be_base = 8'h01;
        ext = uns_q ? {56'b0, shifted[7:0]}
                    : {{56{shifted[7]}}, shifted[7:0]};
      end
      2'd1: begin
        misalign = addr_q[0];
        be_base  = 8'h03;
        ext = uns_q ? {48'b0, shifted[15:0]}
                    : {{48{shifted[15]}}, shifted[15:0]};
      end
      2'd2: begin
        misalign = |addr_q[1:0];
        be_base  = 8'h0F;
        ext = uns_q ? {32'b0, shifted[31:0]}
                    : {{32{shifted[31]}}, shifted[31:0]};
      end
      2'd3: begin
        misalign = |addr_q[2:0];
        be_base  = 8'hFF;
        ext      = shifted;
      end
      default: ;
    endcase
    err_nx = misalign
           | (in_instr & (we_q | (size_q != 2'd2)))
           | (!in_instr & !in_data);
    rdata_nx = 64'b0;
    if (!err_nx && !we_q)
      rdata_nx = in_instr ? {32'b0, im_data} : ext;
    be     = be_base << lane;
    wshift = wdata_q << {lane, 3'b000};
    merged = word;
    for (int b = 0; b < 8; b++)
      if (be[b]) merged[b*8 +: 8] = wshift[b*8 +: 8];
  end

  // Gated by reset so an abandoned write never lands.
  always_ff @(posedge clk) begin
    if (reset && fire && we_q && !err_nx)
      mem[idx] <= merged;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr;
      size_q  <= bus.req_size;
      uns_q   <= bus.req_unsigned;
      wdata_q <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rdata_q <= 64'b0;
      err_q   <= 1'b0;
`ifdef MEM_WAIT_STATES_EN
      cnt_q   <= '0;
`endif
    end else begin
`ifdef MEM_WAIT_STATES_EN
      if (accept)
        cnt_q <= CW'(WAIT_CYCLES);
      else if (state == ACCESS && !done)
        cnt_q <= cnt_q - 1'b1;
`endif
      if (fire) begin
        rdata_q <= rdata_nx;
        err_q   <= err_nx;
      end
    end
  end

endmodule
